bp_fe_fetch_queue: RTL and testbench
====================================

Name: bp_fe_fetch_queue

Overview:
- Parametrised multi-lane fetch queue between the FE fetch stage and the fe_queue consumer (BE issue).
- Successor to the single-entry, single-instruction pass-through FE output: accepts up to lanes_p instructions per cycle and compacts sparse lane valids.
- Buffers up to entries_p fe_queue messages and encodes exception priority into msg_type.
- Supports whole-queue flush on redirect, and presents one message per cycle to the consumer.

Parameters:
entries_p, 8, queue depth in messages; power of two, >= 2*lanes_p
lanes_p, 2, instructions accepted per enqueue cycle; 1..4
vaddr_width_p, 39, PC width
instr_width_p, 32, instruction width
meta_width_p, 64, branch metadata width, shared by all lanes of one enqueue

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-low reset; all state clears while low
flush_i  in  1  drop all buffered messages and any same-cycle enqueue
enq_v_i  in  1  enqueue group valid
enq_lane_v_i  in  lanes_p  per-lane instruction valid; any pattern legal
enq_pc_i  in  lanes_p*vaddr_width_p  per-lane PC, lane 0 in LSBs
enq_instr_i  in  lanes_p*instr_width_p  per-lane instruction
enq_meta_i  in  meta_width_p  branch metadata for the group
enq_itlb_miss_i  in  1  group exception flag
enq_page_fault_i  in  1  group exception flag
enq_access_fault_i  in  1  group exception flag
enq_icache_miss_i  in  1  group exception flag (speculative miss)
enq_ready_and_o  out  1  at least lanes_p free entries
fe_queue_v_o  out  1  head message valid
fe_queue_pc_o  out  vaddr_width_p  head PC
fe_queue_instr_o  out  instr_width_p  head instruction
fe_queue_msg_type_o  out  3  0 fetch, 1 itlb_miss, 2 page_fault, 3 access_fault, 4 icache_miss
fe_queue_meta_o  out  meta_width_p  head branch metadata
fe_queue_yumi_i  in  1  consumer takes head this cycle; legal only when fe_queue_v_o
count_o  out  log2(entries_p)+1  occupied entries

Behaviour:
- Reset (reset_i low, async):
  - rptr = wptr = count = 0; storage cleared.
  - Outputs: fe_queue_v_o=0, count_o=0, enq_ready_and_o=1, all data outputs 0.
- Accept condition: enq_fire = enq_v_i & enq_ready_and_o & ~flush_i.
- enq_ready_and_o = (entries_p - count) >= lanes_p.
  - Driven from registered count only; it does not depend on same-cycle yumi.
- Exception group: any of the four flags set.
  - Writes exactly one entry: PC of lowest-indexed valid lane, or lane 0 if none valid.
  - instr = 0; lane valids otherwise ignored.
  - msg_type priority: itlb_miss > page_fault > access_fault > icache_miss.
- Normal group:
  - Writes popcount(enq_lane_v_i) entries, compacted in ascending lane order at wptr, wptr+1, and so on.
  - msg_type = 0; each entry stores enq_meta_i.
  - Zero valid lanes with enq_fire: no write, no state change.
- Pointers advance modulo entries_p and wrap silently.
  - count_next = count + written - (fe_queue_yumi_i & fe_queue_v_o).
- Simultaneous enqueue and dequeue in one cycle are both honoured.
- Latency: an entry written at edge N is visible on fe_queue_* after edge N. There is no same-cycle bypass.
- fe_queue_v_o = (count != 0). Head data comes directly from storage[rptr].
- Flush:
  - At the edge, rptr = wptr = count = 0.
  - Overrides same-cycle enqueue and yumi.
  - Storage contents are don't-care after flush.
- Assertions:
  - yumi while ~fe_queue_v_o is an error.
  - enq_v_i while ~enq_ready_and_o is dropped silently; the bench flags it.
  - Lane field X when its lane valid is 0 is permitted.

Test Plan:
- Reset low mid-operation with count=5 -> immediately fe_queue_v_o=0, count_o=0, enq_ready_and_o=1; after release, first enqueue is readable next cycle.
- lanes_p=2, enq lane_v=2'b11, PCs 0x1000/0x1004, no yumi -> next cycle count=2, head pc=0x1000 type 0; yumi -> head pc=0x1004.
- Sparse lane_v=2'b10, PC1=0x2004 -> single entry pc=0x2004, count +1 (compaction).
- Exception group with page_fault and icache_miss set, lane_v=2'b11, PC0=0x3000 -> one entry, pc=0x3000, msg_type=2, instr=0.
- Fill to count=7 with entries_p=8 -> enq_ready_and_o=0. Yumi one while enq_v_i -> enqueue dropped, count=6, ready rises next cycle. Continue filling through wrap -> FIFO order is preserved across the pointer wrap.
- count=4, flush_i together with enq_fire and yumi -> next cycle count=0, fe_queue_v_o=0. Enqueue the following cycle -> entry readable at rptr=0.

Source files
------------

// File: rtl/bp_fe_fetch_queue.sv
// Multi-lane FE fetch queue: accepts up to lanes_p instructions per cycle,
// compacts sparse lane valids into consecutive entries, folds group exceptions
// into a single prioritised message, and presents one message per cycle to BE.
module bp_fe_fetch_queue #(
  parameter int entries_p     = 8,
  parameter int lanes_p       = 2,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int meta_width_p  = 64
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               enq_v_i,
  input  logic [lanes_p-1:0]                 enq_lane_v_i,
  input  logic [lanes_p*vaddr_width_p-1:0]   enq_pc_i,
  input  logic [lanes_p*instr_width_p-1:0]   enq_instr_i,
  input  logic [meta_width_p-1:0]            enq_meta_i,
  input  logic                               enq_itlb_miss_i,
  input  logic                               enq_page_fault_i,
  input  logic                               enq_access_fault_i,
  input  logic                               enq_icache_miss_i,
  output logic                               enq_ready_and_o,
  output logic                               fe_queue_v_o,
  output logic [vaddr_width_p-1:0]           fe_queue_pc_o,
  output logic [instr_width_p-1:0]           fe_queue_instr_o,
  output logic [2:0]                         fe_queue_msg_type_o,
  output logic [meta_width_p-1:0]            fe_queue_meta_o,
  input  logic                               fe_queue_yumi_i,
  output logic [$clog2(entries_p):0]         count_o
);

  localparam int PtrW = $clog2(entries_p);
  localparam int CntW = PtrW + 1;

  typedef enum logic [2:0] {
    MsgFetch       = 3'd0,
    MsgItlbMiss    = 3'd1,
    MsgPageFault   = 3'd2,
    MsgAccessFault = 3'd3,
    MsgIcacheMiss  = 3'd4
  } msgType_e;

  logic [PtrW-1:0]          rdPtr_q, rdPtr_d;
  logic [PtrW-1:0]          wrPtr_q, wrPtr_d;
  logic [CntW-1:0]          count_q, count_d;

  logic [vaddr_width_p-1:0] pcMem_q    [entries_p];
  logic [instr_width_p-1:0] instrMem_q [entries_p];
  logic [2:0]               typeMem_q  [entries_p];
  logic [meta_width_p-1:0]  metaMem_q  [entries_p];

  logic                     enqFire;
  logic                     deqFire;
  logic                     isExc;
  msgType_e                 excType;
  logic [CntW-1:0]          nWrite;
  logic [vaddr_width_p-1:0] slotPc     [lanes_p];
  logic [instr_width_p-1:0] slotInstr  [lanes_p];
  logic [PtrW-1:0]          slotAddr   [lanes_p];

  // Ready looks only at the registered count so it never depends on a same-cycle dequeue.
  assign enq_ready_and_o = (CntW'(entries_p) - count_q) >= CntW'(lanes_p);
  assign enqFire         = enq_v_i & enq_ready_and_o & ~flush_i;
  assign deqFire         = fe_queue_yumi_i & fe_queue_v_o;
  assign isExc           = enq_itlb_miss_i | enq_page_fault_i | enq_access_fault_i | enq_icache_miss_i;

  // Fixed-priority encode of the group exception flags into a message type.
  always_comb begin
    excType = MsgFetch;
    if (enq_itlb_miss_i)         excType = MsgItlbMiss;
    else if (enq_page_fault_i)   excType = MsgPageFault;
    else if (enq_access_fault_i) excType = MsgAccessFault;
    else if (enq_icache_miss_i)  excType = MsgIcacheMiss;
  end

  // Build the compacted write slots: one PC-only slot for exceptions, else valid lanes in order.
  always_comb begin
    int rank;
    rank = 0;
    for (int k = 0; k < lanes_p; k++) begin
      slotPc[k]    = '0;
      slotInstr[k] = '0;
      slotAddr[k]  = wrPtr_q + PtrW'(k);
    end
    nWrite = '0;
    if (isExc) begin
      slotPc[0] = enq_pc_i[0 +: vaddr_width_p];
      for (int l = lanes_p - 1; l >= 0; l--) begin
        if (enq_lane_v_i[l]) slotPc[0] = enq_pc_i[l*vaddr_width_p +: vaddr_width_p];
      end
      nWrite = CntW'(1);
    end else begin
      for (int l = 0; l < lanes_p; l++) begin
        if (enq_lane_v_i[l]) begin
          for (int k = 0; k < lanes_p; k++) begin
            if (k == rank) begin
              slotPc[k]    = enq_pc_i[l*vaddr_width_p +: vaddr_width_p];
              slotInstr[k] = enq_instr_i[l*instr_width_p +: instr_width_p];
            end
          end
          rank = rank + 1;
        end
      end
      nWrite = CntW'(rank);
    end
  end

  // Pointer and occupancy next-state; flush wins over both enqueue and dequeue.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (enqFire) wrPtr_d = wrPtr_q + nWrite[PtrW-1:0];
      rdPtr_d = rdPtr_q + PtrW'(deqFire);
      count_d = count_q + (enqFire ? nWrite : CntW'(0)) - CntW'(deqFire);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Message storage; each accepted slot lands at consecutive entries from the write pointer.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int e = 0; e < entries_p; e++) begin
        pcMem_q[e]    <= '0;
        instrMem_q[e] <= '0;
        typeMem_q[e]  <= '0;
        metaMem_q[e]  <= '0;
      end
    end else if (enqFire) begin
      for (int k = 0; k < lanes_p; k++) begin
        if (CntW'(k) < nWrite) begin
          pcMem_q[slotAddr[k]]    <= slotPc[k];
          instrMem_q[slotAddr[k]] <= isExc ? '0 : slotInstr[k];
          typeMem_q[slotAddr[k]]  <= isExc ? excType : MsgFetch;
          metaMem_q[slotAddr[k]]  <= enq_meta_i;
        end
      end
    end
  end

  assign fe_queue_v_o        = (count_q != '0);
  assign fe_queue_pc_o       = pcMem_q[rdPtr_q];
  assign fe_queue_instr_o    = instrMem_q[rdPtr_q];
  assign fe_queue_msg_type_o = typeMem_q[rdPtr_q];
  assign fe_queue_meta_o     = metaMem_q[rdPtr_q];
  assign count_o             = count_q;

  // The consumer may only take the head while a message is present.
  yumiOnlyWhenValid : assert property (@(posedge clk_i) disable iff (!reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Directed bench for bp_fe_fetch_queue: reset, compaction, exception priority,
// full/ready behaviour with pointer wrap, flush, and mid-operation async reset.
module tb_bp_fe_fetch_queue;

  localparam int EntriesP = 8;
  localparam int LanesP   = 2;
  localparam int VaW      = 39;
  localparam int InW      = 32;
  localparam int MetaW    = 64;

  logic                     clk_i;
  logic                     reset_i;
  logic                     flush_i;
  logic                     enq_v_i;
  logic [LanesP-1:0]        enq_lane_v_i;
  logic [LanesP*VaW-1:0]    enq_pc_i;
  logic [LanesP*InW-1:0]    enq_instr_i;
  logic [MetaW-1:0]         enq_meta_i;
  logic                     enq_itlb_miss_i;
  logic                     enq_page_fault_i;
  logic                     enq_access_fault_i;
  logic                     enq_icache_miss_i;
  logic                     enq_ready_and_o;
  logic                     fe_queue_v_o;
  logic [VaW-1:0]           fe_queue_pc_o;
  logic [InW-1:0]           fe_queue_instr_o;
  logic [2:0]               fe_queue_msg_type_o;
  logic [MetaW-1:0]         fe_queue_meta_o;
  logic                     fe_queue_yumi_i;
  logic [$clog2(EntriesP):0] count_o;

  int checks;
  int passes;
  int fails;

  bp_fe_fetch_queue #(
    .entries_p(EntriesP), .lanes_p(LanesP), .vaddr_width_p(VaW),
    .instr_width_p(InW), .meta_width_p(MetaW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .enq_v_i(enq_v_i), .enq_lane_v_i(enq_lane_v_i), .enq_pc_i(enq_pc_i),
    .enq_instr_i(enq_instr_i), .enq_meta_i(enq_meta_i),
    .enq_itlb_miss_i(enq_itlb_miss_i), .enq_page_fault_i(enq_page_fault_i),
    .enq_access_fault_i(enq_access_fault_i), .enq_icache_miss_i(enq_icache_miss_i),
    .enq_ready_and_o(enq_ready_and_o), .fe_queue_v_o(fe_queue_v_o),
    .fe_queue_pc_o(fe_queue_pc_o), .fe_queue_instr_o(fe_queue_instr_o),
    .fe_queue_msg_type_o(fe_queue_msg_type_o), .fe_queue_meta_o(fe_queue_meta_o),
    .fe_queue_yumi_i(fe_queue_yumi_i), .count_o(count_o)
  );

  // Free-running 10ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [InW-1:0] instrOf(input logic [VaW-1:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  function automatic logic [MetaW-1:0] metaOf(input logic [VaW-1:0] pc);
    return 64'hA5A5_0000_0000_0000 | {25'b0, pc};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags = {itlb, page_fault, access_fault, icache_miss}
  task automatic applyStimulus(input logic v, input logic [1:0] laneV,
                               input logic [VaW-1:0] pc0, input logic [VaW-1:0] pc1,
                               input logic [3:0] flags, input logic yumi, input logic flush);
    enq_v_i            = v;
    enq_lane_v_i       = laneV;
    enq_pc_i           = {pc1, pc0};
    enq_instr_i        = {instrOf(pc1), instrOf(pc0)};
    enq_meta_i         = metaOf(pc0);
    enq_itlb_miss_i    = flags[3];
    enq_page_fault_i   = flags[2];
    enq_access_fault_i = flags[1];
    enq_icache_miss_i  = flags[0];
    fe_queue_yumi_i    = yumi;
    flush_i            = flush;
    if (v && !enq_ready_and_o && !flush)
      $display("[TB] note: enq_v_i driven while enq_ready_and_o low, group is dropped");
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, '0, '0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic expV, input int expCount,
                             input logic expReady);
    checkVal({tag, ".v"}, 64'(fe_queue_v_o), 64'(expV));
    checkVal({tag, ".count"}, 64'(count_o), 64'(expCount));
    checkVal({tag, ".ready"}, 64'(enq_ready_and_o), 64'(expReady));
  endtask

  task automatic checkHead(input string tag, input logic [VaW-1:0] expPc,
                           input logic [2:0] expType, input logic [InW-1:0] expInstr);
    checkVal({tag, ".pc"}, 64'(fe_queue_pc_o), 64'(expPc));
    checkVal({tag, ".type"}, 64'(fe_queue_msg_type_o), 64'(expType));
    checkVal({tag, ".instr"}, 64'(fe_queue_instr_o), 64'(expInstr));
  endtask

  // Linear directed sequence.
  initial begin
    logic [VaW-1:0] xPc;
    checks = 0;
    passes = 0;
    fails  = 0;
    xPc    = 'x;
    reset_i = 1'b0;
    idle();
    tick();
    tick();

    checkOutput("reset", 1'b0, 0, 1'b1);
    checkHead("reset", '0, 3'd0, '0);
    checkVal("reset.meta", fe_queue_meta_o, 64'h0);
    reset_i = 1'b1;

    applyStimulus(1'b1, 2'b11, 39'h1000, 39'h1004, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("pair", 1'b1, 2, 1'b1);
    checkHead("pair", 39'h1000, 3'd0, instrOf(39'h1000));
    checkVal("pair.meta", fe_queue_meta_o, metaOf(39'h1000));
    applyStimulus(1'b0, 2'b00, '0, '0, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("pairPop", 1'b1, 1, 1'b1);
    checkHead("pairPop", 39'h1004, 3'd0, instrOf(39'h1004));
    tick();
    checkOutput("pairEmpty", 1'b0, 0, 1'b1);

    applyStimulus(1'b1, 2'b10, xPc, 39'h2004, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("sparse", 1'b1, 1, 1'b1);
    checkHead("sparse", 39'h2004, 3'd0, instrOf(39'h2004));

    applyStimulus(1'b1, 2'b11, 39'h3000, 39'h3004, 4'b0101, 1'b0, 1'b0);
    tick();
    checkOutput("excPf", 1'b1, 2, 1'b1);
    applyStimulus(1'b0, 2'b00, '0, '0, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("excPfPop", 1'b1, 1, 1'b1);
    checkHead("excPf", 39'h3000, 3'd2, '0);
    tick();
    checkOutput("excPfEmpty", 1'b0, 0, 1'b1);

    applyStimulus(1'b1, 2'b00, 39'h3100, 39'h3104, 4'b1010, 1'b0, 1'b0);
    tick();
    checkOutput("excItlb", 1'b1, 1, 1'b1);
    checkHead("excItlb", 39'h3100, 3'd1, '0);
    applyStimulus(1'b1, 2'b10, 39'h3200, 39'h3204, 4'b0010, 1'b1, 1'b0);
    tick();
    checkOutput("excAf", 1'b1, 1, 1'b1);
    checkHead("excAf", 39'h3204, 3'd3, '0);
    applyStimulus(1'b1, 2'b01, 39'h3300, 39'h3304, 4'b0001, 1'b1, 1'b0);
    tick();
    checkOutput("excIc", 1'b1, 1, 1'b1);
    checkHead("excIc", 39'h3300, 3'd4, '0);
    applyStimulus(1'b1, 2'b00, 39'h3400, 39'h3404, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("noLanes", 1'b0, 0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b11, 39'h4000 + 39'(8*i), 39'h4004 + 39'(8*i), 4'b0000, 1'b0, 1'b0);
      tick();
    end
    checkOutput("fill6", 1'b1, 6, 1'b1);
    applyStimulus(1'b1, 2'b01, 39'h4018, xPc, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("fill7", 1'b1, 7, 1'b0);
    checkHead("fill7", 39'h4000, 3'd0, instrOf(39'h4000));
    applyStimulus(1'b1, 2'b11, 39'h5000, 39'h5004, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("dropped", 1'b1, 6, 1'b1);
    checkHead("dropped", 39'h4004, 3'd0, instrOf(39'h4004));
    applyStimulus(1'b1, 2'b11, 39'h401C, 39'h4020, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("full", 1'b1, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkVal("drain.count", 64'(count_o), 64'(8 - i));
      checkHead("drain", 39'h4004 + 39'(4*i), 3'd0, instrOf(39'h4004 + 39'(4*i)));
      applyStimulus(1'b0, 2'b00, '0, '0, 4'b0000, 1'b1, 1'b0);
      tick();
    end
    checkOutput("drained", 1'b0, 0, 1'b1);

    applyStimulus(1'b1, 2'b11, 39'h6000, 39'h6004, 4'b0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b11, 39'h6008, 39'h600C, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("preFlush", 1'b1, 4, 1'b1);
    applyStimulus(1'b1, 2'b11, 39'h6010, 39'h6014, 4'b0000, 1'b1, 1'b1);
    tick();
    checkOutput("flush", 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 2'b01, 39'h7000, xPc, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("postFlush", 1'b1, 1, 1'b1);
    checkHead("postFlush", 39'h7000, 3'd0, instrOf(39'h7000));
    applyStimulus(1'b1, 2'b11, 39'h7004, 39'h7008, 4'b0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b11, 39'h700C, 39'h7010, 4'b0000, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("count5", 1'b1, 5, 1'b1);

    reset_i = 1'b0;
    #1;
    checkOutput("asyncReset", 1'b0, 0, 1'b1);
    checkHead("asyncReset", '0, 3'd0, '0);
    tick();
    reset_i = 1'b1;
    applyStimulus(1'b1, 2'b01, 39'h8000, xPc, 4'b0000, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("afterReset", 1'b1, 1, 1'b1);
    checkHead("afterReset", 39'h8000, 3'd0, instrOf(39'h8000));
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
